// File: rtl/axichannel_replayer.sv
// rtl/axichannel_replayer.sv - replays buffered begin records onto a channel, one at a time gated by end records
module axichannel_replayer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  replay_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  repb_valid,
    output logic                  repb_ready,
    input  logic [DATA_WIDTH-1:0] repb_data,
    input  logic                  repe_valid,
    output logic                  repe_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  mode,
    output logic [CNT_WIDTH-1:0]  issued_cnt,
    output logic [CNT_WIDTH-1:0]  retired_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_END} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  live;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  issue_go;
    logic                  out_hs;
    logic                  repe_hs;
    logic                  mode_load;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // mode only changes in IDLE, so mode==0 always implies the FSM is IDLE
    assign in_ready   = live && !mode && out_ready;
    assign out_valid  = mode ? (state == ISSUE) : (live && in_valid);
    assign out_data   = mode ? out_data_r : in_data;
    assign repb_ready = rstn && live && mode && !full;
    assign repe_ready = rstn && repe_valid &&
                        (((state == ISSUE) && out_ready) || (state == WAIT_END));

    assign push      = repb_valid && repb_ready;
    assign issue_go  = (state == IDLE) && mode && !empty;
    assign out_hs    = (state == ISSUE) && out_ready;
    assign repe_hs   = repe_valid && repe_ready;
    // hold mode on the issue edge so the beat is never presented in passthrough
    assign mode_load = (state == IDLE) && !out_valid && !issue_go;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= repb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_data_r  <= '0;
            mode        <= 1'b0;
            live        <= 1'b0;
            issued_cnt  <= '0;
            retired_cnt <= '0;
        end else begin
            live <= 1'b1;
            if (mode_load) begin
                mode <= replay_en;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (out_hs) begin
                issued_cnt <= issued_cnt + CNT_WIDTH'(1);
            end
            if (repe_hs) begin
                retired_cnt <= retired_cnt + CNT_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (issue_go) begin
                        out_data_r <= mem[rd_ptr[AW-1:0]];
                        rd_ptr     <= rd_ptr + PTR_ONE;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_hs) begin
                        state <= repe_valid ? IDLE : WAIT_END;
                    end
                end
                WAIT_END: begin
                    if (repe_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
